// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state, owner encoding
// and default bus widths.
package pmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around the arbiter.
// slave: the arbiter's view. master: the surrounding requesters and memory.
interface pmem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_rsp_valid;
  logic [DATA_W-1:0]   ifu_rsp_data;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_rsp_valid;
  logic [DATA_W-1:0]   lsu_rsp_data;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/pmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the IFU, bit 1 the LSU.
// On contention the requester that did not win last time is granted.
module rr_arb2
  import pmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the current valids and the previous winner
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU.
// One transaction in flight at a time; the response is returned as a
// single-cycle pulse to whichever requester owns the transaction.
//
// state | meaning
// IDLE  | pick a winner, accept its request
// REQ   | present latched request to memory until accepted
// WAIT  | wait for the memory response, capture its data
// RESP  | pulse rsp_valid to the owner for one cycle
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic         clk,
  input logic         rst,
  pmem_arb_if.slave   bus
);

  localparam int MASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   ifu_data_q, ifu_data_d;
  logic [DATA_W-1:0]   lsu_data_q, lsu_data_d;

  logic [1:0]          grant;
  logic                ifu_ready, lsu_ready;
  logic                mem_valid;
  logic                ifu_pulse, lsu_pulse;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  // Next-state, request latching and handshake outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    ifu_data_d = ifu_data_q;
    lsu_data_d = lsu_data_q;
    ifu_ready  = 1'b0;
    lsu_ready  = 1'b0;
    mem_valid  = 1'b0;
    ifu_pulse  = 1'b0;
    lsu_pulse  = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is withheld during reset so no requester sees a phantom accept
        ifu_ready = grant[0] & ~rst;
        lsu_ready = grant[1] & ~rst;
        if (ifu_ready) begin
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          state_d = REQ;
        end else if (lsu_ready) begin
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (owner_q == OWN_IFU) ifu_data_d = bus.mem_rsp_data;
          else                    lsu_data_d = bus.mem_rsp_data;
          state_d = RESP;
        end
      end
      RESP: begin
        ifu_pulse = (owner_q == OWN_IFU);
        lsu_pulse = (owner_q == OWN_LSU);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IFU;
      last_q     <= OWN_LSU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ifu_data_q <= '0;
      lsu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      ifu_data_q <= ifu_data_d;
      lsu_data_q <= lsu_data_d;
    end
  end

  assign bus.ifu_req_ready = ifu_ready;
  assign bus.lsu_req_ready = lsu_ready;
  assign bus.ifu_rsp_valid = ifu_pulse;
  assign bus.lsu_rsp_valid = lsu_pulse;
  assign bus.ifu_rsp_data  = ifu_data_q;
  assign bus.lsu_rsp_data  = lsu_data_q;
  assign bus.mem_req_valid = mem_valid;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

endmodule
